valu_issue_ctrl: RTL

//   Single-issue sequencer for the vector ALU. Accepts one vector instruction (op, vd, vs1, vs2)

---
 rtl/valu_issue_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/valu_issue_ctrl.sv
// rtl/valu_issue_ctrl.sv - single-issue vector ALU sequencer: VRF read, ALU execute, VRF writeback
module valu_issue_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ELEMENTS   = 8,
  parameter int NUM_VREGS  = 32,
  localparam int ADDR_W    = $clog2(NUM_VREGS),
  localparam int VEC_W     = DATA_WIDTH * ELEMENTS
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              flush_in,
  input  logic              issue_valid_in,
  output logic              issue_ready_o,
  input  logic [3:0]        issue_op_in,
  input  logic [ADDR_W-1:0] issue_vd_in,
  input  logic [ADDR_W-1:0] issue_vs1_in,
  input  logic [ADDR_W-1:0] issue_vs2_in,
  output logic              vrf_rd_en_o,
  output logic [ADDR_W-1:0] vrf_rs1_addr_o,
  output logic [ADDR_W-1:0] vrf_rs2_addr_o,
  input  logic [VEC_W-1:0]  vrf_rs1_data_in,
  input  logic [VEC_W-1:0]  vrf_rs2_data_in,
  output logic [3:0]        valu_op_o,
  output logic [VEC_W-1:0]  valu_vrs1_o,
  output logic [VEC_W-1:0]  valu_vrs2_o,
  input  logic [VEC_W-1:0]  valu_res_in,
  output logic              vrf_wr_en_o,
  input  logic              vrf_wr_ready_in,
  output logic [ADDR_W-1:0] vrf_wr_addr_o,
  output logic [VEC_W-1:0]  vrf_wr_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam logic [3:0] OP_VADD = 4'b0000;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t            state_q, state_d;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] vd_q, vs1_q, vs2_q;
  logic [VEC_W-1:0]  res_q;
  logic              done_q, err_q;
  logic              accept;
  logic              wr_fire;

  always_comb begin
    state_d        = state_q;
    issue_ready_o  = (state_q == S_IDLE) && !flush_in;
    accept         = issue_valid_in && issue_ready_o;
    vrf_rd_en_o    = 1'b0;
    vrf_rs1_addr_o = '0;
    vrf_rs2_addr_o = '0;
    valu_op_o      = '0;
    valu_vrs1_o    = '0;
    valu_vrs2_o    = '0;
    vrf_wr_en_o    = 1'b0;
    vrf_wr_addr_o  = '0;
    vrf_wr_data_o  = '0;
    case (state_q)
      S_IDLE: begin
        if (accept && issue_op_in == OP_VADD) state_d = S_READ;
      end
      S_READ: begin
        vrf_rd_en_o    = 1'b1;
        vrf_rs1_addr_o = vs1_q;
        vrf_rs2_addr_o = vs2_q;
        state_d        = S_EXEC;
      end
      S_EXEC: begin
        valu_op_o   = op_q;
        valu_vrs1_o = vrf_rs1_data_in;
        valu_vrs2_o = vrf_rs2_data_in;
        state_d     = S_WB;
      end
      S_WB: begin
        // A flush must win over a coincident grant so no partial write escapes.
        vrf_wr_en_o   = !flush_in;
        vrf_wr_addr_o = vd_q;
        vrf_wr_data_o = res_q;
        if (vrf_wr_ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_in) state_d = S_IDLE;
    wr_fire = vrf_wr_en_o && vrf_wr_ready_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      vd_q    <= '0;
      vs1_q   <= '0;
      vs2_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= wr_fire;
      err_q   <= accept && (issue_op_in != OP_VADD);
      if (accept) begin
        op_q  <= issue_op_in;
        vd_q  <= issue_vd_in;
        vs1_q <= issue_vs1_in;
        vs2_q <= issue_vs2_in;
      end
      if (state_q == S_EXEC) res_q <= valu_res_in;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q;
  assign err_o  = err_q;

endmodule
